// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multi-cycle IEEE-754 single-precision multiplier.
// The significands are multiplied with a shift-add loop, then the product
// is normalised, rounded to nearest-even, range-checked and packed.
// The start/done handshake matches the team's Newton-Raphson divider.
// Define FP_MUL_RADIX4_EN to retire two multiplier bits per cycle
// (12 MUL cycles instead of 24); results and flags are identical.
// Handshake: start is sampled only while idle (busy=0). busy rises at the
// accepting edge and falls at the edge that raises done. done is a one-cycle
// strobe. R and flags hold their value until the next done.
module fp_mul_seq #(
    parameter int EXP_BIAS = 127,
    parameter int MANT_W   = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] R,
    output logic [3:0]  flags
);
    localparam int SIG_W = MANT_W + 1;
    localparam int P_W   = 2 * SIG_W;
`ifdef FP_MUL_RADIX4_EN
    localparam logic [4:0] LAST_CNT = 5'(SIG_W / 2 - 1);
`else
    localparam logic [4:0] LAST_CNT = 5'(SIG_W - 1);
`endif

    typedef enum logic [1:0] {IDLE, MUL, RND, OUT} state_t;
    state_t state, state_next;

    logic [P_W-1:0]     acc;
    logic [SIG_W-1:0]   mcand;
    logic [SIG_W-1:0]   mplier;
    logic [4:0]         cnt;
    logic               sign_q;
    logic signed [9:0]  exp_base;
    logic [31:0]        spec_r_q;
    logic [3:0]         spec_f_q;
`ifdef FP_MUL_RADIX4_EN
    logic [SIG_W+1:0]   mcand3;
`endif

    // Operand decode of the live inputs; only used at the accepting edge.
    logic [7:0]  ea, eb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_in;
    logic        special;
    logic [31:0] spec_r;
    logic [3:0]  spec_f;

    // Classify operands and form the special-case result.
    always_comb begin
        ea      = A[30:23];
        eb      = B[30:23];
        sign_in = A[31] ^ B[31];
        a_nan   = (ea == 8'hFF) && (A[MANT_W-1:0] != '0);
        b_nan   = (eb == 8'hFF) && (B[MANT_W-1:0] != '0);
        a_inf   = (ea == 8'hFF) && (A[MANT_W-1:0] == '0);
        b_inf   = (eb == 8'hFF) && (B[MANT_W-1:0] == '0);
        a_zero  = (ea == 8'h00);
        b_zero  = (eb == 8'h00);
        special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        spec_r  = {sign_in, 31'd0};
        spec_f  = 4'b0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_r = 32'h7FC0_0000;
            spec_f = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_r = {sign_in, 8'hFF, 23'd0};
        end
    end

    // Partial product added into the accumulator on each MUL cycle.
    logic [P_W-1:0] addend;
    always_comb begin
        addend = '0;
`ifdef FP_MUL_RADIX4_EN
        case (mplier[1:0])
            2'd1:    addend = {{(P_W-SIG_W-2){1'b0}}, 2'b00, mcand} << {cnt, 1'b0};
            2'd2:    addend = {{(P_W-SIG_W-2){1'b0}}, 1'b0, mcand, 1'b0} << {cnt, 1'b0};
            2'd3:    addend = {{(P_W-SIG_W-2){1'b0}}, mcand3} << {cnt, 1'b0};
            default: addend = '0;
        endcase
`else
        if (mplier[0]) addend = {{(P_W-SIG_W){1'b0}}, mcand} << cnt;
`endif
    end

    // Normalise, round to nearest-even and range-check the finished product.
    logic               norm, guard, sticky, inc, carry;
    logic [MANT_W-1:0]  mant_pre, mant_rnd;
    logic signed [9:0]  exp1, exp2;
    logic [31:0]        rnd_r;
    logic [3:0]         rnd_f;
    always_comb begin
        norm     = acc[P_W-1];
        mant_pre = norm ? acc[P_W-2 -: MANT_W] : acc[P_W-3 -: MANT_W];
        guard    = norm ? acc[SIG_W-1] : acc[SIG_W-2];
        sticky   = norm ? (|acc[SIG_W-2:0]) : (|acc[SIG_W-3:0]);
        inc      = guard & (sticky | mant_pre[0]);
        {carry, mant_rnd} = {1'b0, mant_pre} + {{MANT_W{1'b0}}, inc};
        exp1     = exp_base + (norm ? 10'sd1 : 10'sd0);
        exp2     = exp1 + (carry ? 10'sd1 : 10'sd0);
        rnd_r    = {sign_q, exp2[7:0], mant_rnd};
        rnd_f    = {3'b000, guard | sticky};
        if (exp2 >= 10'sd255) begin
            rnd_r = {sign_q, 8'hFF, 23'd0};
            rnd_f = 4'b0101;
        end else if (exp2 <= 10'sd0) begin
            rnd_r = {sign_q, 31'd0};
            rnd_f = 4'b0011;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = special ? OUT : MUL;
            MUL:     if (cnt == LAST_CNT) state_next = RND;
            RND:     state_next = IDLE;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Datapath: operand capture, shift-add loop and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            exp_base <= '0;
            spec_r_q <= '0;
            spec_f_q <= '0;
`ifdef FP_MUL_RADIX4_EN
            mcand3   <= '0;
`endif
            done     <= 1'b0;
            R        <= '0;
            flags    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    acc      <= '0;
                    mcand    <= {1'b1, A[MANT_W-1:0]};
                    mplier   <= {1'b1, B[MANT_W-1:0]};
                    cnt      <= '0;
                    sign_q   <= sign_in;
                    exp_base <= 10'({2'b00, ea}) + 10'({2'b00, eb}) - 10'(EXP_BIAS);
                    spec_r_q <= spec_r;
                    spec_f_q <= spec_f;
`ifdef FP_MUL_RADIX4_EN
                    mcand3   <= {2'b01, A[MANT_W-1:0]} + {1'b1, A[MANT_W-1:0], 1'b0};
`endif
                end
                MUL: begin
                    acc <= acc + addend;
`ifdef FP_MUL_RADIX4_EN
                    mplier <= mplier >> 2;
`else
                    mplier <= mplier >> 1;
`endif
                    cnt <= cnt + 5'd1;
                end
                RND: begin
                    R     <= rnd_r;
                    flags <= rnd_f;
                    done  <= 1'b1;
                end
                OUT: begin
                    R     <= spec_r_q;
                    flags <= spec_f_q;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
